// File: rtl/mult_div_unit.sv
// Iterative 32-bit signed multiply (radix-2 Booth) / divide (restoring) unit, Hi/Lo results.
// Define MULTDIV_DIV_EN to build the divider; without it DivStart is ignored and DivZero is 0.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        MultStart,
    input  logic        DivStart,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        Busy,
    output logic        Done,
    output logic        DivZero
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q;
    logic [64:0] prod_q;
    logic [31:0] mcand_q;
    logic [31:0] hi_q, lo_q;
    logic        last_step;
    logic        div_go;
    logic [32:0] booth_acc;
    logic [64:0] prod_nxt;

    assign last_step = (cnt_q == 5'd31);

    // The 33-bit sum keeps the true sign (e.g. subtracting 0x80000000) and becomes the new top after the shift.
    always_comb begin
        booth_acc = {prod_q[64], prod_q[64:33]};
        case (prod_q[1:0])
            2'b01:   booth_acc = booth_acc + {mcand_q[31], mcand_q};
            2'b10:   booth_acc = booth_acc - {mcand_q[31], mcand_q};
            default: booth_acc = {prod_q[64], prod_q[64:33]};
        endcase
        prod_nxt = {booth_acc, prod_q[32:1]};
    end

`ifdef MULTDIV_DIV_EN
    logic [31:0] rem_q, quo_q, dvs_q;
    logic        qneg_q, rneg_q, dz_q;
    logic [32:0] rem_sh, rem_diff;
    logic [31:0] rem_nxt, quo_nxt;
    logic [31:0] a_mag, b_mag;

    assign div_go = DivStart & ~MultStart;
    assign a_mag  = A[31] ? -A : A;
    assign b_mag  = B[31] ? -B : B;

    always_comb begin
        rem_sh   = {rem_q, quo_q[31]};
        rem_diff = rem_sh - {1'b0, dvs_q};
        if (!rem_diff[32]) begin
            rem_nxt = rem_diff[31:0];
            quo_nxt = {quo_q[30:0], 1'b1};
        end else begin
            rem_nxt = rem_sh[31:0];
            quo_nxt = {quo_q[30:0], 1'b0};
        end
    end
`else
    logic unused_div;
    assign div_go     = 1'b0;
    assign unused_div = DivStart;
`endif

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (MultStart)   state_d = MULT;
                else if (div_go) state_d = (B == 32'd0) ? DONE : DIV;
            end
            MULT: if (last_step) state_d = DONE;
`ifdef MULTDIV_DIV_EN
            DIV:  if (last_step) state_d = DONE;
`else
            DIV:  state_d = IDLE;
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        Busy    = (state_q == MULT) || (state_q == DIV);
        Done    = (state_q == DONE);
`ifdef MULTDIV_DIV_EN
        DivZero = (state_q == DONE) && dz_q;
`else
        DivZero = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MULTDIV_DIV_EN
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef MULTDIV_DIV_EN
                    dz_q <= 1'b0;
`endif
                    if (MultStart) begin
                        mcand_q <= A;
                        prod_q  <= {32'd0, B, 1'b0};
                        cnt_q   <= '0;
                    end
`ifdef MULTDIV_DIV_EN
                    else if (div_go) begin
                        dz_q   <= (B == 32'd0);
                        rem_q  <= '0;
                        quo_q  <= a_mag;
                        dvs_q  <= b_mag;
                        qneg_q <= A[31] ^ B[31];
                        rneg_q <= A[31];
                        cnt_q  <= '0;
                    end
`endif
                end
                MULT: begin
                    prod_q <= prod_nxt;
                    cnt_q  <= cnt_q + 5'd1;
                    if (last_step) begin
                        hi_q <= prod_nxt[64:33];
                        lo_q <= prod_nxt[32:1];
                    end
                end
`ifdef MULTDIV_DIV_EN
                DIV: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q + 5'd1;
                    // Quotient truncates toward zero; remainder takes the dividend's sign.
                    if (last_step) begin
                        lo_q <= qneg_q ? -quo_nxt : quo_nxt;
                        hi_q <= rneg_q ? -rem_nxt : rem_nxt;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign HiOut = hi_q;
    assign LoOut = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed ops push expected Hi/Lo/DivZero; a monitor checks on Done.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset, MultStart, DivStart;
    logic [31:0] A, B;
    logic [31:0] HiOut, LoOut;
    logic        Busy, Done, DivZero;

    int n_checks = 0;
    int n_err    = 0;
    logic [64:0] exp_q[$];

    mult_div_unit dut (
        .clk(clk), .reset(reset), .MultStart(MultStart), .DivStart(DivStart),
        .A(A), .B(B), .HiOut(HiOut), .LoOut(LoOut),
        .Busy(Busy), .Done(Done), .DivZero(DivZero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every Done pulse must match the oldest outstanding expectation.
    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (Done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_done: got Done=1 hi=%h lo=%h expected no result", HiOut, LoOut);
                end else begin
                    e = exp_q.pop_front();
                    chk("result_hi", HiOut, e[64:33]);
                    chk("result_lo", LoOut, e[32:1]);
                    chk("divzero", {31'd0, DivZero}, {31'd0, e[0]});
                end
            end else if (DivZero !== 1'b0) begin
                n_checks++;
                n_err++;
                $display("FAIL divzero_without_done: got %b expected 0", DivZero);
            end
        end
    end

    task automatic start(input logic ms, input logic ds, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        MultStart = ms; DivStart = ds; A = a; B = b;
        @(posedge clk);
        #1;
        MultStart = 1'b0; DivStart = 1'b0; A = $urandom; B = $urandom;
    endtask

    // Counts cycles after the accepting edge until Done; Busy must be high before, low at Done.
    task automatic wait_done(input int elat);
        int lat = 0;
        logic busy_ok = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (Done === 1'b1) begin
                lat = i;
                if (Busy !== 1'b0) busy_ok = 1'b0;
                break;
            end
            if (Busy !== 1'b1) busy_ok = 1'b0;
        end
        chk("latency", 32'(lat), 32'(elat));
        chk("busy_window", {31'd0, busy_ok}, 32'd1);
    endtask

    task automatic run_op(input logic ms, input logic ds, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic edz, input int elat);
        exp_q.push_back({ehi, elo, edz});
        start(ms, ds, a, b);
        wait_done(elat);
    endtask

    task automatic quiet(input int n, input string name);
        logic ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (Busy !== 1'b0 || Done !== 1'b0 || DivZero !== 1'b0) ok = 1'b0;
        end
        chk(name, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        reset = 1'b1; MultStart = 1'b0; DivStart = 1'b0; A = '0; B = '0;
        repeat (2) @(posedge clk);
        // Start coincident with reset must be dropped.
        @(negedge clk);
        MultStart = 1'b1; A = 32'd5; B = 32'd5;
        @(posedge clk);
        #1;
        MultStart = 1'b0; reset = 1'b0;
        @(negedge clk);
        chk("reset_hi", HiOut, 32'd0);
        chk("reset_lo", LoOut, 32'd0);
        chk("reset_flags", {29'd0, Busy, Done, DivZero}, 32'd0);
        quiet(40, "start_with_reset_ignored");

        run_op(1, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 33);
        run_op(1, 0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 33);
        run_op(1, 0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 0, 33);
        run_op(1, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 0, 33);
        run_op(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0, 33);
        run_op(1, 1, 32'd6, 32'd3, 32'h00000000, 32'h00000012, 0, 33);

        // Restart pulse during Busy: single Done carrying the first operation's result.
        exp_q.push_back({32'h00000000, 32'h00000FFF, 1'b0});
        start(1, 0, 32'h00000FFF, 32'h00000001);
        fork
            wait_done(33);
            begin
                repeat (4) @(negedge clk);
                MultStart = 1'b1; A = 32'd100; B = 32'd100;
                @(negedge clk);
                MultStart = 1'b0;
            end
        join
        quiet(40, "no_second_done");

`ifdef MULTDIV_DIV_EN
        run_op(0, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 33);
        run_op(0, 1, 32'd9, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 1);
        run_op(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 33);
        run_op(0, 1, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 0, 33);
        run_op(0, 1, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 33);
`else
        start(0, 1, 32'd10, 32'd2);
        quiet(40, "divstart_ignored");
        chk("hold_hi", HiOut, 32'h00000000);
        chk("hold_lo", LoOut, 32'h00000FFF);
`endif

        // Abort mid-multiply: no commit, outputs cleared, no Done.
        run_op(1, 0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 33);
        start(1, 0, 32'd3, 32'd3);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_hi", HiOut, 32'd0);
        chk("abort_lo", LoOut, 32'd0);
        chk("abort_flags", {29'd0, Busy, Done, DivZero}, 32'd0);
        quiet(40, "abort_no_done");

        run_op(1, 0, 32'd3, 32'd3, 32'h00000000, 32'h00000009, 0, 33);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have no parameters; operand and result width is fixed at 32 bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port MultStart, input, 1 bit: request a signed multiply of A by B.
REQ-005 SHALL have port DivStart, input, 1 bit: request a signed divide of A by B.
REQ-006 SHALL have port A, input, 32 bits: multiplicand or dividend, sampled only on the accepting edge.
REQ-007 SHALL have port B, input, 32 bits: multiplier or divisor, sampled only on the accepting edge.
REQ-008 SHALL have port HiOut, output, 32 bits: Hi register feeding the Hi/Lo select ahead of the register-file write-data mux.
REQ-009 SHALL have port LoOut, output, 32 bits: Lo register, same destination as HiOut.
REQ-010 SHALL have port Busy, output, 1 bit: high while an operation is iterating.
REQ-011 SHALL have port Done, output, 1 bit: one-cycle pulse when a result is committed.
REQ-012 SHALL have port DivZero, output, 1 bit: one-cycle pulse, coincident with Done, on a divide by zero.

Function
REQ-013 SHALL implement the FSM states IDLE, MULT, DIV and DONE.
REQ-014 In IDLE, a start on a rising edge SHALL latch A and B, clear the step counter, and move to MULT or DIV.
REQ-015 When MultStart and DivStart are both high, SHALL give priority to MultStart and ignore DivStart.
REQ-016 In MULT, SHALL perform one radix-2 Booth step per cycle over a 65-bit product/multiplier register, for 32 steps.
REQ-017 In DIV, SHALL perform one restoring step per cycle on magnitudes, for 32 steps, and apply signs at commit.
REQ-018 After step 32, SHALL write HiOut/LoOut and move to DONE; DONE SHALL return to IDLE after one cycle.
REQ-019 Timing: with the start accepted at edge N, Done SHALL be high in the cycle after edge N+32 (33-cycle latency).
REQ-020 Busy SHALL be high in MULT and DIV only; Done SHALL be high in DONE only.
REQ-021 Multiply result SHALL be the 64-bit signed product, with Hi = [63:32] and Lo = [31:0].
REQ-022 Divide result SHALL set Lo = quotient (truncated toward zero) and Hi = remainder (sign of dividend).
REQ-023 Divide of 0x80000000 by 0xFFFFFFFF SHALL give Lo = 0x80000000 and Hi = 0, and SHALL NOT pulse DivZero.
REQ-024 If B = 0 when DivStart is accepted, SHALL go straight to DONE; DivZero and Done SHALL pulse one cycle later, and HiOut/LoOut SHALL be unchanged.
REQ-025 Starts while not in IDLE SHALL be ignored; they are neither queued nor able to corrupt latched operands.
REQ-026 Between operations, SHALL hold HiOut/LoOut unchanged; they change only at commit or reset.
REQ-027 A start may be accepted in IDLE on the cycle immediately after DONE (back-to-back operation).

Reset
REQ-028 Reset SHALL force state to IDLE, set HiOut = LoOut = 0, set Busy = Done = DivZero = 0, and clear the counter and working registers.
REQ-029 Reset SHALL take priority over any start and SHALL abort an operation in progress without committing a partial result.
REQ-030 A start asserted together with reset SHALL be ignored.

Configuration
REQ-031 With macro MULTDIV_DIV_EN defined, SHALL build the divider datapath and the DIV state as specified above.
REQ-032 Without MULTDIV_DIV_EN, SHALL omit the divider: DivStart is ignored (FSM stays in IDLE), DivZero is tied to 0, and multiply behaviour is identical.

Verification
REQ-033 Apply MultStart with A = 7, B = -3 -> Done at cycle 33, Hi = 0xFFFFFFFF, Lo = 0xFFFFFFEB, Busy high for cycles 1-32.
REQ-034 Apply MultStart with A = 0x80000000, B = 0x80000000 -> Hi = 0x40000000, Lo = 0x00000000.
REQ-035 Apply DivStart with A = -7, B = 2 -> Lo = 0xFFFFFFFD, Hi = 0xFFFFFFFF; then DivStart with B = 0 -> Done and DivZero pulse at cycle 1 with Hi/Lo unchanged.
REQ-036 Assert reset at cycle 10 of a multiply -> next cycle shows IDLE, Hi = Lo = 0, no Done pulse; MultStart and DivStart together -> multiply performed.
REQ-037 Pulse MultStart again during Busy -> ignored, single Done; build without MULTDIV_DIV_EN and apply DivStart -> Busy, Done and DivZero stay 0.
